// File: rtl/cam_pkg.sv
// ============================================================================
//  Module : cam_pkg
//  Brief  : Shared encodings for the CAM entry manager: command opcodes,
//           response status codes and controller state constants.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    // Command opcodes; the opcode doubles as the CAM write_delete flag
    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    // Response status codes
    typedef logic [1:0] status_t;
    localparam status_t ST_OK       = 2'd0;
    localparam status_t ST_DUP      = 2'd1;
    localparam status_t ST_FULL     = 2'd2;
    localparam status_t ST_NOTFOUND = 2'd3;

    // Controller states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/priority_encoder.sv
// ============================================================================
//  Module : priority_encoder
//  Brief  : Combinational priority encoder. LSB_PRIORITY = "HIGH" makes the
//           lowest set index win; anything else makes the highest index win.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW",
    localparam int   ENC_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [ENC_W-1:0] output_encoded
);

    assign output_valid = |input_unencoded;

    generate
        if (LSB_PRIORITY == "HIGH") begin : g_lsb_high
            // Scan downwards so the last (lowest) set bit wins
            always_comb begin
                output_encoded = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (input_unencoded[i]) begin
                        output_encoded = ENC_W'(i);
                    end
                end
            end
        end else begin : g_msb_high
            // Scan upwards so the last (highest) set bit wins
            always_comb begin
                output_encoded = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (input_unencoded[i]) begin
                        output_encoded = ENC_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cam_entry_mgr.sv
// ============================================================================
//  Module : cam_entry_mgr
//  Brief  : Command-side controller for the SRL-based CAM. Turns keyed
//           INSERT/DELETE commands into lookup-then-write sequences, keeps
//           the valid bitmap and entry count, allocates the lowest free
//           entry and returns one status response per command.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_entry_mgr
    import cam_pkg::*;
#(
    parameter int  DATA_WIDTH  = 64,
    parameter int  ADDR_WIDTH  = 5,
    parameter int  SLICE_WIDTH = 4,
    localparam int MASK_W      = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH,
    localparam int ENTRIES     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_key,
    input  logic [MASK_W-1:0]     cmd_mask,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,

    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    output logic [MASK_W-1:0]     cam_select_mask,
    input  logic [ENTRIES-1:0]    cam_match_many,

    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] C_ENTRIES = (ADDR_WIDTH + 1)'(ENTRIES);
    localparam logic [ADDR_WIDTH:0] C_ONE     = (ADDR_WIDTH + 1)'(1);

    logic [2:0]            r_state;
    logic                  r_op;
    logic [DATA_WIDTH-1:0] r_key;
    logic [MASK_W-1:0]     r_mask;
    logic [ENTRIES-1:0]    r_valid;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    status_t               r_status;

    logic [ENTRIES-1:0]    w_hit_vec;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_hit_addr;
    logic                  w_free_valid;
    logic [ADDR_WIDTH-1:0] w_free_addr;

    // Stale match bits from never-written or deleted entries are masked off
    assign w_hit_vec = cam_match_many & r_valid;

    priority_encoder #(
        .WIDTH        (ENTRIES),
        .LSB_PRIORITY ("HIGH")
    ) u_hit_enc (
        .input_unencoded (w_hit_vec),
        .output_valid    (w_hit),
        .output_encoded  (w_hit_addr)
    );

    priority_encoder #(
        .WIDTH        (ENTRIES),
        .LSB_PRIORITY ("HIGH")
    ) u_free_enc (
        .input_unencoded (~r_valid),
        .output_valid    (w_free_valid),
        .output_encoded  (w_free_addr)
    );

    // Held key/mask drive both the compare port and the write port; the
    // opcode doubles as the delete flag
    assign cam_compare_data = r_key;
    assign cam_select_mask  = r_mask;
    assign cam_write_data   = r_key;
    assign cam_write_addr   = r_addr;
    assign cam_write_delete = r_op;
    assign cam_write_enable = (r_state == S_ISSUE) & ~rst;

    assign cmd_ready   = (r_state == S_IDLE) & ~cam_write_busy & ~rst;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_status  = r_status;
    assign rsp_addr    = r_addr;

    assign entry_count = r_count;
    assign full        = (r_count == C_ENTRIES);
    assign empty       = (r_count == '0);

    // Command sequencing: accept, look up, decide, write, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_INSERT;
            r_key    <= '0;
            r_mask   <= '0;
            r_valid  <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_status <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_op    <= cmd_op;
                        r_key   <= cmd_key;
                        r_mask  <= cmd_mask;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // CAM registers its match vector during this cycle
                    r_state <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (r_op == OP_DELETE) begin
                        if (w_hit) begin
                            r_addr  <= w_hit_addr;
                            r_state <= S_ISSUE;
                        end else begin
                            r_status <= ST_NOTFOUND;
                            r_addr   <= '0;
                            r_state  <= S_RESP;
                        end
                    end else if (w_hit) begin
                        r_status <= ST_DUP;
                        r_addr   <= w_hit_addr;
                        r_state  <= S_RESP;
                    end else if (full || !w_free_valid) begin
                        r_status <= ST_FULL;
                        r_addr   <= '0;
                        r_state  <= S_RESP;
                    end else begin
                        r_addr  <= w_free_addr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!cam_write_busy) begin
                        r_valid[r_addr] <= (r_op == OP_INSERT);
                        r_count  <= (r_op == OP_INSERT) ? (r_count + C_ONE)
                                                        : (r_count - C_ONE);
                        r_status <= ST_OK;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cam_entry_mgr.sv
// ============================================================================
//  Module : tb_cam_entry_mgr
//  Brief  : Self-checking bench for cam_entry_mgr with a behavioural SRL CAM
//           model (init busy after reset, 15-cycle write busy, registered
//           match vector). Expected responses go into a scoreboard queue.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_entry_mgr;
    import cam_pkg::*;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int SW = 4;
    localparam int MW = 4;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [DW-1:0] cmd_key = '0;
    logic [MW-1:0] cmd_mask = 4'hF;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic [MW-1:0] cam_select_mask;
    logic [N-1:0]  cam_match_many;
    logic [AW:0]   entry_count;
    logic          full;
    logic          empty;

    cam_entry_mgr #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SLICE_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_key          (cmd_key),
        .cmd_mask         (cmd_mask),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_status       (rsp_status),
        .rsp_addr         (rsp_addr),
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_write_busy   (cam_write_busy),
        .cam_compare_data (cam_compare_data),
        .cam_select_mask  (cam_select_mask),
        .cam_match_many   (cam_match_many),
        .entry_count      (entry_count),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural CAM model ----------------
    logic [DW-1:0] m_entry [N];
    logic [N-1:0]  m_vld   = '0;
    logic          m_busy  = 1'b0;
    logic          m_wr    = 1'b0;
    int            m_cnt   = 0;
    logic [AW-1:0] m_wa    = '0;
    logic [DW-1:0] m_wd    = '0;
    logic          m_wdel  = 1'b0;
    logic [N-1:0]  m_match = '0;

    assign cam_write_busy = m_busy;
    assign cam_match_many = m_match;

    // Reset: 16 busy cycles of init; write: busy from the next cycle for 15
    always @(posedge clk) begin
        if (rst) begin
            m_vld   <= '0;
            m_busy  <= 1'b1;
            m_cnt   <= 15;
            m_wr    <= 1'b0;
            m_match <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                m_match[i] <= m_vld[i] && (m_entry[i] == cam_compare_data);
            if (cam_write_enable) begin
                m_busy <= 1'b1;
                m_cnt  <= 14;
                m_wr   <= 1'b1;
                m_wa   <= cam_write_addr;
                m_wd   <= cam_write_data;
                m_wdel <= cam_write_delete;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_wr   <= 1'b0;
                    if (m_wr) begin
                        m_entry[m_wa] <= m_wd;
                        m_vld[m_wa]   <= !m_wdel;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]    st;
        logic [AW-1:0] addr;
        int            lat;
        int            writes;
        logic          del;
        logic [DW-1:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks accepts and write pulses, checks responses against queue
    initial begin : monitor
        int            acc_cyc;
        int            wr_cnt;
        logic          wr_del;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          prev_v;
        logic          prev_r;
        logic [1:0]    hold_st;
        logic [AW-1:0] hold_addr;
        exp_t          e;
        acc_cyc = 0; wr_cnt = 0; wr_del = 0; wr_addr = '0; wr_data = '0;
        prev_v = 0; prev_r = 1; hold_st = '0; hold_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
                prev_r = 1;
            end else begin
                if (cam_write_enable) begin
                    wr_cnt++;
                    wr_del  = cam_write_delete;
                    wr_addr = cam_write_addr;
                    wr_data = cam_write_data;
                end
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc;
                    wr_cnt  = 0;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        if (!prev_v) chk("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_v)
                            chk("latency", cyc - acc_cyc, e.lat);
                        else if (!prev_r) begin
                            chk("hold_status", 32'(rsp_status), 32'(hold_st));
                            chk("hold_addr", 32'(rsp_addr), 32'(hold_addr));
                        end
                        hold_st   = rsp_status;
                        hold_addr = rsp_addr;
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            chk("rsp_status", 32'(rsp_status), 32'(e.st));
                            chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                            chk("write_pulses", wr_cnt, e.writes);
                            if (e.writes > 0) begin
                                chk("write_delete", 32'(wr_del), 32'(e.del));
                                chk("write_addr", 32'(wr_addr), 32'(e.addr));
                                chk("write_data", 32'(wr_data), 32'(e.key));
                            end
                        end
                    end
                end
                prev_v = rsp_valid;
                prev_r = rsp_ready;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic op, input logic [DW-1:0] key, input logic push,
                         input logic [1:0] st, input logic [AW-1:0] addr,
                         input int lat, input int writes, output int waited);
        exp_t e;
        if (push) begin
            e.st = st; e.addr = addr; e.lat = lat; e.writes = writes;
            e.del = op; e.key = key;
            exp_q.push_back(e);
        end
        cmd_op    = op;
        cmd_key   = key;
        cmd_valid = 1'b1;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 32'(cmd_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic run(input logic op, input logic [DW-1:0] key,
                       input logic [1:0] st, input logic [AW-1:0] addr, input int lat);
        int w;
        issue(op, key, 1'b1, st, addr, lat, (lat == 20) ? 1 : 0, w);
        wait_rsp();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_wr_en"}, 32'(cam_write_enable), 0);
        chk({tag, "_count"}, 32'(entry_count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_wr_addr"}, 32'(cam_write_addr), 0);
        chk({tag, "_cmp_data"}, 32'(cam_compare_data), 0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        // Command held through CAM init; ready must stay low >= 16 cycles
        @(posedge clk);
        #1 rst = 1'b0;
        issue(OP_INSERT, 16'h1234, 1'b1, ST_OK, 2'd0, 20, 1, w);
        n_tests++;
        if (w < 16) begin
            n_fail++;
            $display("FAIL init_wait: got %0d cycles expected at least 16", w);
        end
        chk("count_before_write", 32'(entry_count), 0);
        chk("empty_before_write", 32'(empty), 1);
        wait_rsp();

        run(OP_INSERT, 16'hABCD, ST_OK, 2'd1, 20);
        chk("count_after_2", 32'(entry_count), 2);
        run(OP_INSERT, 16'h1234, ST_DUP, 2'd0, 3);
        run(OP_INSERT, 16'h1111, ST_OK, 2'd2, 20);
        run(OP_INSERT, 16'h2222, ST_OK, 2'd3, 20);
        chk("count_full", 32'(entry_count), 4);
        chk("full_flag", 32'(full), 1);
        run(OP_INSERT, 16'h5555, ST_FULL, 2'd0, 3);
        chk("count_after_full", 32'(entry_count), 4);
        run(OP_DELETE, 16'hABCD, ST_OK, 2'd1, 20);
        chk("count_after_del", 32'(entry_count), 3);
        chk("full_after_del", 32'(full), 0);
        run(OP_INSERT, 16'h7777, ST_OK, 2'd1, 20);
        chk("count_after_reuse", 32'(entry_count), 4);
        run(OP_DELETE, 16'h9999, ST_NOTFOUND, 2'd0, 3);

        // Response back-pressure: hold rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        issue(OP_DELETE, 16'h1111, 1'b1, ST_OK, 2'd2, 20, 1, w);
        w = 0;
        while (!rsp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_rsp();
        chk("count_after_hold", 32'(entry_count), 3);

        // Reset while the write is in flight
        issue(OP_INSERT, 16'h3333, 1'b0, ST_OK, 2'd0, 0, 0, w);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_wr_en", 32'(cam_write_enable), 0);
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        run(OP_INSERT, 16'h4444, ST_OK, 2'd0, 20);
        chk("count_after_rst", 32'(entry_count), 1);
        chk("empty_after_rst", 32'(empty), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/cam_entry_mgr.md
Name: cam_entry_mgr

Overview:
- Command-side controller for the SRL-based CAM. Drives the CAM's write port (write_addr/data/delete/enable, honouring write_busy) and its compare port.
- Turns keyed INSERT/DELETE requests into lookup-then-write sequences. Keeps a valid bitmap, allocates the lowest free entry, and returns one status response per command.
- Sits between the SIMD dispatch logic and the CAM instance.

Parameters:
- DATA_WIDTH, 64, key width; must equal the CAM's DATA_WIDTH.
- ADDR_WIDTH, 5, log2 of entry count; must equal the CAM's ADDR_WIDTH.
- SLICE_WIDTH, 4, CAM slice width; MASK_W = ceil(DATA_WIDTH/SLICE_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; shared with the CAM instance
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = INSERT, 1 = DELETE
- cmd_key  in  DATA_WIDTH  search/insert key
- cmd_mask  in  MASK_W  slice select, forwarded to the CAM select_mask
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_status  out  2  0 OK, 1 DUP, 2 FULL, 3 NOTFOUND
- rsp_addr  out  ADDR_WIDTH  entry written, hit, or deleted; 0 for FULL/NOTFOUND
- cam_write_addr  out  ADDR_WIDTH
- cam_write_data  out  DATA_WIDTH
- cam_write_delete  out  1
- cam_write_enable  out  1  single-cycle pulse
- cam_write_busy  in  1
- cam_compare_data  out  DATA_WIDTH
- cam_select_mask  out  MASK_W
- cam_match_many  in  2**ADDR_WIDTH  registered CAM match vector
- entry_count  out  ADDR_WIDTH+1  number of valid entries
- full  out  1  entry_count == 2**ADDR_WIDTH
- empty  out  1  entry_count == 0

Behaviour:
- Reset values:
  - state IDLE; valid bitmap 0; entry_count 0; empty 1; full 0.
  - cmd_ready 0, rsp_valid 0, cam_write_enable 0.
  - All CAM address, data and compare outputs 0; rsp_status 0; rsp_addr 0.
- cmd_ready = (state == IDLE) & ~cam_write_busy. It is therefore 0 during CAM init after reset.
- FSM transitions:
  - IDLE: on accept, latch op, key and mask. Drive cam_compare_data = key and cam_select_mask = mask, and hold both until RESP. Go to LOOKUP.
  - LOOKUP: 1 cycle; the CAM registers its match. Go to DECIDE.
  - DECIDE: compute hit_vec = cam_match_many & valid, then hit_addr = lowest set index.
    - INSERT, hit: DUP, rsp_addr = hit_addr.
    - INSERT, no hit, full: FULL.
    - INSERT, otherwise: addr = lowest clear bit of valid; go to ISSUE.
    - DELETE, no hit: NOTFOUND.
    - DELETE, hit: addr = hit_addr; go to ISSUE.
    - Non-write outcomes go to RESP.
  - ISSUE: pulse cam_write_enable for exactly 1 cycle. Drive cam_write_addr = addr, cam_write_data = key, cam_write_delete = op. Go to WAIT.
  - WAIT: stay while cam_write_busy = 1. The CAM asserts busy on the cycle after enable. On busy = 0:
    - INSERT sets valid[addr]; DELETE clears it.
    - entry_count updates in the same edge.
    - Status OK, rsp_addr = addr. Go to RESP.
  - RESP: rsp_valid = 1. Status and address stay stable until rsp_valid & rsp_ready, then go to IDLE. No new command is accepted while a response is pending.
- Latency, accept to rsp_valid:
  - DUP/FULL/NOTFOUND: 3 cycles.
  - OK: 4 + 2**SLICE_WIDTH cycles (20 for SLICE_WIDTH = 4).
- Hit qualification with the valid bitmap guards against stale match bits. Multiple hits resolve to the lowest index.
- Match semantics follow the CAM: a hit means a selected slice matched. The manager does no extra key compare.
- rsp_ready held high gives back-to-back commands with 1 idle cycle between response and the next accept.
- Reset mid-operation: rst aborts any state to IDLE and clears valid/count. Since the CAM receives the same rst, its contents re-initialise and stay consistent. A write_enable pulse is never emitted in the reset cycle.
- entry_count never under- or overflows; FULL is reported before any write is attempted.

Decomposition:
- Package cam_pkg:
  - op encodings (OP_INSERT = 0, OP_DELETE = 1);
  - status encodings (ST_OK, ST_DUP, ST_FULL, ST_NOTFOUND);
  - FSM state constants.
- Sub-modules: reuse the existing priority_encoder (LSB_PRIORITY "HIGH") twice:
  - on hit_vec to find the hit address;
  - on ~valid to find the free address.

Test Plan (DATA_WIDTH = 16, ADDR_WIDTH = 2, SLICE_WIDTH = 4, mask = 4'hF, manager connected to the real CAM):
- After rst, hold cmd_valid: cmd_ready stays 0 for ≥ 16 cycles of CAM init, then rises; entry_count = 0, empty = 1.
- INSERT 0x1234 → OK, addr 0, rsp_valid 20 cycles after accept. INSERT 0xABCD → OK, addr 1. entry_count = 2.
- INSERT 0x1234 again → DUP, addr 0, 3-cycle latency, no cam_write_enable pulse.
- Fill all 4 entries, then INSERT 0x5555 → FULL, addr 0, full = 1, count stays 4.
- DELETE 0xABCD → OK, addr 1, cam_write_delete = 1 during the enable pulse. Next INSERT 0x7777 → OK, addr 1 (lowest free reused). DELETE 0x9999 → NOTFOUND.
- Hold rsp_ready = 0 for 5 cycles: rsp_valid and rsp_status stable, cmd_ready 0. Assert rst during WAIT: outputs return to reset values and a subsequent INSERT lands at addr 0.
